// File: rtl/digit_pkg.sv
// Shared constants, FSM state type and BCD helper for the digit clock display.
package digit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } clk_state_e;

  localparam logic [7:0] HOUR_MAX     = 8'h23;
  localparam logic [7:0] MIN_MAX      = 8'h59;
  localparam int         SYNC_DEPTH   = 2;
  localparam int         PRIME_CYCLES = 3;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [7:0] SEG_DASH   = 8'hBF;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  // Index n holds the active-low pattern for digit n.
  localparam logic [9:0][7:0] SEG_DIGIT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Two-digit BCD increment that wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim)             r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/digit_clock_display_if.sv
// Divider/button inputs and display/time outputs of the digit clock display.
interface digit_clock_display_if;
  logic        sec_clk;
  logic        ms_4_clk;
  logic        btn_mode;
  logic        btn_inc;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [23:0] time_bcd;

  modport master (output sec_clk, ms_4_clk, btn_mode, btn_inc,
                  input  an, seg, time_bcd);
  modport slave  (input  sec_clk, ms_4_clk, btn_mode, btn_inc,
                  output an, seg, time_bcd);
endinterface

// File: rtl/digit_clock_display_seg7_decoder.sv
// 4-bit display code to active-low {dp,g,f,e,d,c,b,a}; 0-9 digits, A dash, rest blank.
module seg7_decoder
  import digit_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9)            seg = SEG_DIGIT[code];
    else if (code == CODE_DASH)  seg = SEG_DASH;
  end
endmodule

// File: rtl/digit_clock_display.sv
// 24h BCD clock with set mode and 8-digit multiplexed display.
// Optional build macro SET_BLINK_EN blanks the field being set while sync sec_clk is high.
module digit_clock_display
  import digit_pkg::*;
(
  input logic                  clk_input,
  input logic                  rst,
  digit_clock_display_if.slave bus
);
  localparam int NIN  = 4;
  localparam int SEC  = 0;
  localparam int SCAN = 1;
  localparam int MODE = 2;
  localparam int INC  = 3;

  logic [NIN-1:0]                 raw, lvl, prev_q, ev_q;
  logic [SYNC_DEPTH-1:0][NIN-1:0] sync_q;
  logic [PRIME_CYCLES-1:0]        vld_pipe;
  logic                           primed;

  assign raw    = {bus.btn_inc, bus.btn_mode, bus.ms_4_clk, bus.sec_clk};
  assign lvl    = sync_q[SYNC_DEPTH-1];
  assign primed = vld_pipe[PRIME_CYCLES-1];

  // Square waves act on both edges, buttons on rising edges only; the divider's
  // unreset start-up level is swallowed until primed.
  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= '0;
      ev_q     <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_DEPTH-2:0], raw};
      prev_q   <= lvl;
      vld_pipe <= {vld_pipe[PRIME_CYCLES-2:0], 1'b1};
      ev_q     <= primed ? {lvl[INC:MODE] & ~prev_q[INC:MODE], lvl[SCAN:SEC] ^ prev_q[SCAN:SEC]}
                         : '0;
    end
  end

  clk_state_e st_q, st_n;
  logic [7:0] hh_q, mm_q, ss_q, hh_n, mm_n, ss_n;
  logic [2:0] idx_q, idx_n;
  logic [7:0] an_q, seg_q, dec_seg;
  logic [3:0] code, dec_code;
  logic       blank;

  always_comb begin
    st_n = st_q;
    hh_n = hh_q;
    mm_n = mm_q;
    ss_n = ss_q;
    unique case (st_q)
      RUN: begin
        if (ev_q[MODE]) st_n = SET_HOUR;
        else if (ev_q[SEC]) begin
          ss_n = bcd_inc(ss_q, MIN_MAX);
          if (ss_q == MIN_MAX) begin
            mm_n = bcd_inc(mm_q, MIN_MAX);
            if (mm_q == MIN_MAX) hh_n = bcd_inc(hh_q, HOUR_MAX);
          end
        end
      end
      SET_HOUR: begin
        if (ev_q[MODE])     st_n = SET_MIN;
        else if (ev_q[INC]) hh_n = bcd_inc(hh_q, HOUR_MAX);
      end
      SET_MIN: begin
        if (ev_q[MODE]) begin
          st_n = RUN;
          ss_n = 8'h00;
        end else if (ev_q[INC]) mm_n = bcd_inc(mm_q, MIN_MAX);
      end
      default: st_n = RUN;
    endcase
  end

  // Display is built from next-state values so an/seg track time_bcd in the same cycle.
  always_comb begin
    idx_n = idx_q + {2'b00, ev_q[SCAN]};
    code  = CODE_BLANK;
    case (idx_n)
      3'd0: code = ss_n[3:0];
      3'd1: code = ss_n[7:4];
      3'd2: code = CODE_DASH;
      3'd3: code = mm_n[3:0];
      3'd4: code = mm_n[7:4];
      3'd5: code = CODE_DASH;
      3'd6: code = hh_n[3:0];
      3'd7: code = hh_n[7:4];
      default: code = CODE_BLANK;
    endcase
`ifdef SET_BLINK_EN
    blank = lvl[SEC] & (((st_n == SET_HOUR) && (idx_n[2:1] == 2'b11)) ||
                        ((st_n == SET_MIN)  && ((idx_n == 3'd3) || (idx_n == 3'd4))));
`else
    blank = 1'b0;
`endif
    dec_code = blank ? CODE_BLANK : code;
  end

  seg7_decoder u_dec (
    .code (dec_code),
    .seg  (dec_seg)
  );

  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      st_q  <= RUN;
      hh_q  <= 8'h00;
      mm_q  <= 8'h00;
      ss_q  <= 8'h00;
      idx_q <= 3'd0;
      an_q  <= 8'hFE;
      seg_q <= SEG_DIGIT[0];
    end else begin
      st_q  <= st_n;
      hh_q  <= hh_n;
      mm_q  <= mm_n;
      ss_q  <= ss_n;
      idx_q <= idx_n;
      an_q  <= blank ? 8'hFF : ~(8'd1 << idx_n);
      seg_q <= dec_seg;
    end
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.time_bcd = {hh_q, mm_q, ss_q};

endmodule

// File: tb/tb_digit_clock_display.sv
// Directed bench for digit_clock_display: per-cycle time-of-day model plus literal checkpoints.
module tb_digit_clock_display;
  logic clk_input = 1'b0;
  logic rst;

  digit_clock_display_if bus();

  digit_clock_display dut (
    .clk_input (clk_input),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk_input = ~clk_input;

  int n_vec = 0;
  int n_bad = 0;

  // model: plain time-of-day in integers, mode 0=run 1=set hour 2=set minute
  int h, m, s, idx, mst;
  logic [3:0] lvl [0:5];

  int          lit_tag  = 0;
  int          lit_seen = 0;
  int          lit_kind = 0;
  logic [23:0] lit_e    = '0;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, ex);
    end
  endtask

  always @(negedge clk_input) begin
    logic [3:0]  cur, nw, od;
    logic        tk, sc, md, ic, blank;
    int          tot;
    int          dig [8];
    logic [23:0] et;
    logic [7:0]  ea, es;
    cur = {bus.btn_inc, bus.btn_mode, bus.ms_4_clk, bus.sec_clk};
    if (rst) begin
      h = 0; m = 0; s = 0; idx = 0; mst = 0;
      for (int i = 0; i < 6; i++) lvl[i] = cur;
    end else begin
      for (int i = 5; i > 0; i--) lvl[i] = lvl[i-1];
      lvl[0] = cur;
      // an input change made just after edge n takes effect at edge n+4
      nw = lvl[4];
      od = lvl[5];
      tk = nw[0] ^ od[0];
      sc = nw[1] ^ od[1];
      md = nw[2] & ~od[2];
      ic = nw[3] & ~od[3];
      if (sc) idx = (idx + 1) % 8;
      if (md) begin
        mst = (mst + 1) % 3;
        if (mst == 0) s = 0;
      end else if (mst == 0 && tk) begin
        tot = (h * 3600 + m * 60 + s + 1) % 86400;
        h = tot / 3600;
        m = (tot / 60) % 60;
        s = tot % 60;
      end else if (mst == 1 && ic) h = (h + 1) % 24;
      else if (mst == 2 && ic) m = (m + 1) % 60;
    end

    et  = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    dig = '{s % 10, s / 10, 10, m % 10, m / 10, 10, h % 10, h / 10};
    blank = 1'b0;
`ifdef SET_BLINK_EN
    blank = !rst && lvl[3][0] && ((mst == 1 && idx >= 6) || (mst == 2 && (idx == 3 || idx == 4)));
`endif
    ea = blank ? 8'hFF : ~(8'd1 << idx);
    es = blank ? 8'hFF : seg_of(dig[idx]);
    check("time_bcd", bus.time_bcd, et);
    check("an", {16'h0, bus.an}, {16'h0, ea});
    check("seg", {16'h0, bus.seg}, {16'h0, es});

    if (lit_tag != lit_seen) begin
      lit_seen = lit_tag;
      case (lit_kind)
        0:       check("lit_time_bcd", bus.time_bcd, lit_e);
        1:       check("lit_an", {16'h0, bus.an}, lit_e);
        default: check("lit_seg", {16'h0, bus.seg}, lit_e);
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_input);
    #1;
  endtask

  task automatic lit(input int kind, input logic [23:0] e);
    step(5);
    lit_kind = kind;
    lit_e    = e;
    lit_tag++;
    step(1);
  endtask

  task automatic tog_sec();
    bus.sec_clk = ~bus.sec_clk;
    step(3);
  endtask

  task automatic tog_ms();
    bus.ms_4_clk = ~bus.ms_4_clk;
    step(3);
  endtask

  task automatic press(input int which, input int times);
    for (int i = 0; i < times; i++) begin
      if (which == 0) bus.btn_mode = 1'b1; else bus.btn_inc = 1'b1;
      step(2);
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      step(2);
    end
  endtask

  logic [7:0] an_t  [8];
  logic [7:0] seg_t [8];

  initial begin
    an_t  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_t = '{8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
    rst = 1'b1;
    bus.sec_clk  = 1'b1;
    bus.ms_4_clk = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step(3);
    lit(0, 24'h000000);
    lit(1, 24'h0000FE);
    lit(2, 24'h0000C0);

    // sec_clk high through reset must not count as a tick
    rst = 1'b0;
    step(8);
    lit(0, 24'h000000);
    tog_sec();
    lit(0, 24'h000001);

    // set mode to 05:01:00, ticks frozen while setting
    press(0, 1);
    press(1, 5);
    tog_sec();
    tog_sec();
    press(0, 1);
    press(1, 61);
    press(0, 1);
    lit(0, 24'h050100);

    // full-day rollover
    press(0, 1);
    press(1, 18);
    press(0, 1);
    press(1, 58);
    press(0, 1);
    lit(0, 24'h235900);
    for (int i = 0; i < 60; i++) tog_sec();
    lit(0, 24'h000000);

    // hour wrap without carry
    press(0, 1);
    press(1, 23);
    lit(0, 24'h230000);
    press(1, 1);
    lit(0, 24'h000000);
    press(0, 2);

    // mode press and tick in the same cycle: mode wins
    for (int i = 0; i < 10; i++) tog_sec();
    lit(0, 24'h000010);
    bus.btn_mode = 1'b1;
    bus.sec_clk  = ~bus.sec_clk;
    step(2);
    bus.btn_mode = 1'b0;
    step(2);
    lit(0, 24'h000010);
    tog_sec();
    lit(0, 24'h000010);
    press(1, 1);
    lit(0, 24'h010010);
    press(0, 2);
    lit(0, 24'h010000);

    // scan sequence at 12:34:56
    press(0, 1);
    press(1, 11);
    press(0, 1);
    press(1, 34);
    press(0, 1);
    for (int i = 0; i < 56; i++) tog_sec();
    lit(0, 24'h123456);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tog_ms();
      lit(1, {16'h0, an_t[k % 8]});
      lit(2, {16'h0, seg_t[k % 8]});
    end

    // minute digits while setting minutes with sync sec_clk high
    press(0, 2);
    if (bus.sec_clk == 1'b0) tog_sec();
    for (int i = 0; i < 3; i++) tog_ms();
`ifdef SET_BLINK_EN
    lit(1, 24'h0000FF);
    lit(2, 24'h0000FF);
`else
    lit(1, 24'h0000F7);
    lit(2, 24'h000099);
`endif
    tog_ms();
`ifdef SET_BLINK_EN
    lit(1, 24'h0000FF);
    lit(2, 24'h0000FF);
`else
    lit(1, 24'h0000EF);
    lit(2, 24'h0000B0);
`endif

    // reset in the middle of SET_MIN
    rst = 1'b1;
    step(1);
    lit(0, 24'h000000);
    lit(1, 24'h0000FE);
    lit(2, 24'h0000C0);
    rst = 1'b0;
    step(8);
    tog_sec();
    lit(0, 24'h000001);

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/digit_clock_display.md
# digit_clock_display

Time-keeping and display stage of the digital clock, directly downstream of the clock divider. It consumes the divider's seconds square wave and scan square wave, sampling both as data in the 100 MHz domain. It maintains a 24-hour BCD hh:mm:ss count with a button-driven set mode. It drives an 8-digit, multiplexed, active-low seven-segment display.

## Interface
- No parameters; all constants live in `digit_pkg`.
- `clk_input`  in  1: 100 MHz system clock; the only clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `sec_clk`  in  1: seconds square wave from the divider; every transition (rise or fall) is one second.
- `ms_4_clk`  in  1: scan square wave from the divider; every transition advances the scan digit.
- `btn_mode`  in  1: debounced button level; acts on its rising edge.
- `btn_inc`  in  1: debounced button level; acts on its rising edge.
- `an`  out  8: digit enables, active-low; bit 0 is the rightmost digit.
- `seg`  out  8: segments {dp,g,f,e,d,c,b,a}, active-low.
- `time_bcd`  out  24: {H1,H0,M1,M0,S1,S0}, 4-bit BCD each.

## Operation
- **Input conditioning.** All four inputs pass through a 2-flop synchronizer and then an edge detector that compares against the previous synchronized value.
  - Tick: any change of sync `sec_clk`.
  - Scan step: any change of sync `ms_4_clk`.
  - Button press: 0→1 of the synced button.
- **Prime.** Edges are ignored until a `primed` flag sets, 3 cycles after `rst` deasserts. This absorbs the divider's unreset initial levels.
- **FSM states:** RUN, SET_HOUR, SET_MIN. Reset state is RUN.
  - RUN: a tick increments S with carry. S 59→00 carries into M; M 59→00 carries into H; H 23→00. So 23:59:59 → 00:00:00. `btn_inc` is ignored.
  - RUN + mode press → SET_HOUR.
  - SET_HOUR: ticks are ignored (time frozen). An inc press does H 23→00 wrap with no carry. A mode press → SET_MIN.
  - SET_MIN: ticks are ignored. An inc press does M 59→00 wrap with no carry. A mode press → RUN and clears S to 00 in the same cycle.
- **Simultaneous events**
  - Mode press + tick in RUN: the transition is taken and the tick is dropped.
  - Mode press + inc press in a set state: mode wins and inc is dropped.
  - Tick + scan step: independent; both are taken.
- **Display**
  - Scan index is 3 bits: 0 at reset, +1 per scan step, wraps 7→0.
  - `an` = ~(1<<idx).
  - Digit contents (7..0): H1 H0 '-' M1 M0 '-' S1 S0.
  - Codes: '0'=C0 '1'=F9 '2'=A4 '3'=B0 '4'=99 '5'=92 '6'=82 '7'=F8 '8'=80 '9'=90 '-'=BF blank=FF (hex). dp is always off.
- **Reset mid-operation.** Everything returns to its reset value immediately (asynchronous), whatever the FSM state.
- **Reset values**
  - `time_bcd`=0.
  - `an`=8'hFE.
  - `seg`=8'hC0 (digit 0 showing '0').
  - FSM=RUN.
  - Synchronizers and `primed` = 0.

## Timing
- `sec_clk` transition → `time_bcd` update: 4 cycles (2 sync + edge + register).
- Button edge → state/field change: 4 cycles.
- `ms_4_clk` transition → `an`/`seg` change: 4 cycles. `an` and `seg` change in the same cycle, with no glitch cycle between them.
- Every output is registered.
- Minimum spacing for two events to both register: 2 cycles. Transitions closer than this are coalesced or lost.

## Configuration
- `SET_BLINK_EN` defined:
  - In SET_HOUR, the H1/H0 digits output blank (`an` bit high, `seg`=FF) while sync `sec_clk`=1.
  - In SET_MIN, the same applies to M1/M0.
- `SET_BLINK_EN` undefined: no blanking; set fields display steadily.
- In both builds, `time_bcd` is unaffected.

## Structure
- `digit_pkg` contains:
  - the FSM state enum;
  - BCD limits (23, 59);
  - segment code constants (digit codes, dash, blank);
  - synchronizer depth (2).
- Sub-module `seg7_decoder`: 4-bit code → 8-bit active-low segments, purely combinational, instantiated once. Codes 0–9 are digits, A is dash, F and other values are blank. Its output is registered in the parent.

## Test plan
- **Rollover.** Preload via set mode to 23:59, mode press back to RUN (time 23:59:00), then drive 60 `sec_clk` transitions → `time_bcd`=24'h000000.
- **Prime.** Hold `sec_clk`=1 through reset; release `rst` → no tick, `time_bcd`=0. The first real transition then gives 24'h000001, 4 cycles after the edge.
- **Set mode.**
  - 3 mode presses with 5 inc presses in SET_HOUR and 61 in SET_MIN → 05:01:00.
  - Ticks during set are ignored.
  - H wrap: from 23, one inc press → 00.
- **Simultaneous.** In RUN at 00:00:10, assert a mode press and a `sec_clk` transition in the same cycle → state SET_HOUR, `time_bcd` stays 24'h000010.
- **Scan.**
  - At 12:34:56, 8 `ms_4_clk` transitions → `an` sequence FE,FD,…,7F.
  - `seg` sequence 82,92,BF,99,B0,BF,A4,F9.
  - The 9th transition → FE again.
- **Blink (`SET_BLINK_EN`).** In SET_MIN with sync `sec_clk`=1, `an` for digits 3 and 4 is never low and `seg`=FF in those slots. With the macro undefined, the digits show normally.
